// File: rtl/st7735_pkg.sv
// Shared ST7735 link definitions: opcodes,
// receiver FSM states and default panel size.
package st7735_pkg;

   localparam logic [7:0] CMD_CASET = 8'h2A;
   localparam logic [7:0] CMD_RASET = 8'h2B;
   localparam logic [7:0] CMD_RAMWR = 8'h2C;

   localparam int LCD_WIDTH  = 128;
   localparam int LCD_HEIGHT = 160;

   typedef enum logic [2:0] {
      IDLE,
      CASET,
      RASET,
      RAMWR_HI,
      RAMWR_LO
   } rx_state_t;

   // Window is legal only with zero high bytes,
   // start <= end and end below the panel limit.
   function automatic logic win_ok(
      input logic [7:0] s_hi,
      input logic [7:0] s_lo,
      input logic [7:0] e_hi,
      input logic [7:0] e_lo,
      input logic [8:0] lim
   );
      return (s_hi == 8'd0) && (e_hi == 8'd0) &&
             (s_lo <= e_lo) && ({1'b0, e_lo} < lim);
   endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// Oversampling SPI byte receiver: synchronizers,
// clock edge detect, shift register and CS abort.
module spi_byte_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cs,
   input  logic       mosi,
   input  logic       dc,
   input  logic       sclk,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       byte_dc,
   output logic       err
);

   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic [SYNC_STAGES-1:0] dc_sync;
   logic [SYNC_STAGES-1:0] sclk_sync;

   logic       cs_s;
   logic       mosi_s;
   logic       dc_s;
   logic       sclk_s;
   logic       cs_q;
   logic       sclk_q;
   logic       sclk_rise;
   logic       cs_fall;
   logic       cs_rise;
   logic [2:0] cnt;
   logic [7:0] shreg;
   logic       dc_q;
   logic       done;

   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];
   assign dc_s   = dc_sync[SYNC_STAGES-1];
   assign sclk_s = sclk_sync[SYNC_STAGES-1];

   assign sclk_rise = sclk_s & ~sclk_q;
   assign cs_fall   = ~cs_s & cs_q;
   assign cs_rise   = cs_s & ~cs_q;

   // Input synchronizers plus one delay stage
   // for edge detection; CS idles high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_sync   <= '1;
         mosi_sync <= '0;
         dc_sync   <= '0;
         sclk_sync <= '0;
         cs_q      <= 1'b1;
         sclk_q    <= 1'b0;
      end else begin
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         dc_sync   <= {dc_sync[SYNC_STAGES-2:0], dc};
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         cs_q      <= cs_s;
         sclk_q    <= sclk_s;
      end
   end

   // Bit shifting; a CS rise mid-byte drops
   // the partial byte and flags an error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= 3'd0;
         shreg <= 8'd0;
         dc_q  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (cs_fall) begin
            cnt <= 3'd0;
         end else if (cs_rise) begin
            err <= (cnt != 3'd0);
            cnt <= 3'd0;
         end else if (!cs_s && sclk_rise) begin
            shreg <= {shreg[6:0], mosi_s};
            cnt   <= cnt + 3'd1;
            if (cnt == 3'd7) begin
               done <= 1'b1;
               dc_q <= dc_s;
            end
         end
      end
   end

   // Present the completed byte one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_valid <= 1'b0;
         byte_data  <= 8'd0;
         byte_dc    <= 1'b0;
      end else begin
         byte_valid <= done;
         if (done) begin
            byte_data <= shreg;
            byte_dc   <= dc_q;
         end
      end
   end

endmodule

// File: rtl/st7735_spi_rx.sv
// ST7735 display-side receiver: command FSM,
// address window and RGB565 pixel pointer.
module st7735_spi_rx
   import st7735_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int WIDTH       = LCD_WIDTH,
   parameter int HEIGHT      = LCD_HEIGHT
) (
   input  logic        SYSTEM_CLK,
   input  logic        RST_N,
   input  logic        CS,
   input  logic        MOSI,
   input  logic        DC,
   input  logic        LCD_CLK,
   output logic        BYTE_VALID,
   output logic [7:0]  BYTE_DATA,
   output logic        BYTE_IS_DATA,
   output logic        PIXEL_VALID,
   output logic [15:0] PIXEL,
   output logic [7:0]  PIXEL_X,
   output logic [7:0]  PIXEL_Y,
   output logic        FRAME_DONE,
   output logic        ERR
);

   localparam logic [8:0] W_LIM = 9'(WIDTH);
   localparam logic [8:0] H_LIM = 9'(HEIGHT);
   localparam logic [7:0] X_MAX = 8'(WIDTH - 1);
   localparam logic [7:0] Y_MAX = 8'(HEIGHT - 1);

   logic       bv;
   logic [7:0] bdata;
   logic       bdc;
   logic       rx_err;
   logic       win_err;

   rx_state_t  state;
   logic [1:0] idx;
   logic [7:0] sh0;
   logic [7:0] sh1;
   logic [7:0] sh2;
   logic [7:0] xs;
   logic [7:0] xe;
   logic [7:0] ys;
   logic [7:0] ye;
   logic [7:0] x;
   logic [7:0] y;
   logic [7:0] hi;
   logic [8:0] lim;
   logic       ok;

   spi_byte_rx #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_rx (
      .clk       (SYSTEM_CLK),
      .rst_n     (RST_N),
      .cs        (CS),
      .mosi      (MOSI),
      .dc        (DC),
      .sclk      (LCD_CLK),
      .byte_valid(bv),
      .byte_data (bdata),
      .byte_dc   (bdc),
      .err       (rx_err)
   );

   assign BYTE_VALID   = bv;
   assign BYTE_DATA    = bdata;
   assign BYTE_IS_DATA = bdc;
   assign ERR          = rx_err | win_err;

   assign lim = (state == CASET) ? W_LIM : H_LIM;
   assign ok  = win_ok(sh0, sh1, sh2, bdata, lim);

   // Command FSM: window capture and pixel assembly,
   // pointer advances as each pixel is emitted.
   always_ff @(posedge SYSTEM_CLK or negedge RST_N) begin
      if (!RST_N) begin
         state       <= IDLE;
         idx         <= 2'd0;
         sh0         <= 8'd0;
         sh1         <= 8'd0;
         sh2         <= 8'd0;
         xs          <= 8'd0;
         xe          <= X_MAX;
         ys          <= 8'd0;
         ye          <= Y_MAX;
         x           <= 8'd0;
         y           <= 8'd0;
         hi          <= 8'd0;
         PIXEL_VALID <= 1'b0;
         PIXEL       <= 16'd0;
         PIXEL_X     <= 8'd0;
         PIXEL_Y     <= 8'd0;
         FRAME_DONE  <= 1'b0;
         win_err     <= 1'b0;
      end else begin
         PIXEL_VALID <= 1'b0;
         FRAME_DONE  <= 1'b0;
         win_err     <= 1'b0;
         if (bv && !bdc) begin
            idx <= 2'd0;
            unique case (bdata)
               CMD_CASET: state <= CASET;
               CMD_RASET: state <= RASET;
               CMD_RAMWR: begin
                  state <= RAMWR_HI;
                  x     <= xs;
                  y     <= ys;
               end
               default: state <= IDLE;
            endcase
         end else if (bv) begin
            unique case (state)
               IDLE: begin
               end
               CASET, RASET: begin
                  idx <= idx + 2'd1;
                  unique case (idx)
                     2'd0: sh0 <= bdata;
                     2'd1: sh1 <= bdata;
                     2'd2: sh2 <= bdata;
                     default: begin
                        state <= IDLE;
                        if (!ok) begin
                           win_err <= 1'b1;
                        end else if (state == CASET) begin
                           xs <= sh1;
                           xe <= bdata;
                        end else begin
                           ys <= sh1;
                           ye <= bdata;
                        end
                     end
                  endcase
               end
               RAMWR_HI: begin
                  hi    <= bdata;
                  state <= RAMWR_LO;
               end
               RAMWR_LO: begin
                  PIXEL_VALID <= 1'b1;
                  PIXEL       <= {hi, bdata};
                  PIXEL_X     <= x;
                  PIXEL_Y     <= y;
                  state       <= RAMWR_HI;
                  if (x == xe) begin
                     x <= xs;
                     if (y == ye) begin
                        y          <= ys;
                        FRAME_DONE <= 1'b1;
                     end else begin
                        y <= y + 8'd1;
                     end
                  end else begin
                     x <= x + 8'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_st7735_spi_rx.sv
// Directed bench for the ST7735 receiver:
// byte table plus CS, abort and reset sequences.
module tb_st7735_spi_rx;

   logic        SYSTEM_CLK = 1'b0;
   logic        RST_N;
   logic        CS;
   logic        MOSI;
   logic        DC;
   logic        LCD_CLK;
   logic        BYTE_VALID;
   logic [7:0]  BYTE_DATA;
   logic        BYTE_IS_DATA;
   logic        PIXEL_VALID;
   logic [15:0] PIXEL;
   logic [7:0]  PIXEL_X;
   logic [7:0]  PIXEL_Y;
   logic        FRAME_DONE;
   logic        ERR;

   st7735_spi_rx dut (
      .SYSTEM_CLK  (SYSTEM_CLK),
      .RST_N       (RST_N),
      .CS          (CS),
      .MOSI        (MOSI),
      .DC          (DC),
      .LCD_CLK     (LCD_CLK),
      .BYTE_VALID  (BYTE_VALID),
      .BYTE_DATA   (BYTE_DATA),
      .BYTE_IS_DATA(BYTE_IS_DATA),
      .PIXEL_VALID (PIXEL_VALID),
      .PIXEL       (PIXEL),
      .PIXEL_X     (PIXEL_X),
      .PIXEL_Y     (PIXEL_Y),
      .FRAME_DONE  (FRAME_DONE),
      .ERR         (ERR)
   );

   always #5 SYSTEM_CLK = ~SYSTEM_CLK;

   typedef struct {
      logic        dc;
      logic [7:0]  b;
      int          ex_err;
      int          ex_pix;
      logic [15:0] px;
      logic [7:0]  x;
      logic [7:0]  y;
      int          ex_fd;
   } vec_t;

   vec_t tbl[$];

   int errors = 0;
   int checks = 0;

   int          byte_n = 0;
   int          pix_n  = 0;
   int          err_n  = 0;
   int          fd_n   = 0;
   logic [7:0]  last_b;
   logic        last_dc;
   logic [15:0] last_px;
   logic [7:0]  last_x;
   logic [7:0]  last_y;

   // Event monitor sampled on the falling edge
   always @(negedge SYSTEM_CLK) begin
      if (BYTE_VALID) begin
         byte_n++;
         last_b  = BYTE_DATA;
         last_dc = BYTE_IS_DATA;
      end
      if (PIXEL_VALID) begin
         pix_n++;
         last_px = PIXEL;
         last_x  = PIXEL_X;
         last_y  = PIXEL_Y;
      end
      if (FRAME_DONE) fd_n++;
      if (ERR) err_n++;
   end

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge SYSTEM_CLK);
   endtask

   // LCD_CLK at SYSTEM_CLK/8, MSB first
   task automatic send_bits(input logic [7:0] b,
                            input logic d,
                            input int n);
      for (int i = 7; i > 7 - n; i--) begin
         MOSI = b[i];
         DC   = d;
         cyc(4);
         LCD_CLK = 1'b1;
         cyc(4);
         LCD_CLK = 1'b0;
      end
   endtask

   task automatic add(input logic dc,
                      input logic [7:0] b,
                      input int e,
                      input int p,
                      input logic [15:0] px,
                      input logic [7:0] x,
                      input logic [7:0] y,
                      input int fd);
      vec_t v;
      v.dc = dc; v.b = b; v.ex_err = e;
      v.ex_pix = p; v.px = px; v.x = x;
      v.y = y; v.ex_fd = fd;
      tbl.push_back(v);
   endtask

   task automatic all_zero(input string nm);
      chk(nm, {19'd0, BYTE_VALID, BYTE_DATA,
               BYTE_IS_DATA, PIXEL_VALID, PIXEL,
               PIXEL_X, PIXEL_Y, FRAME_DONE, ERR},
          64'd0);
   endtask

   int b0, p0, e0, f0;

   initial begin
      RST_N   = 1'b0;
      CS      = 1'b1;
      MOSI    = 1'b0;
      DC      = 1'b0;
      LCD_CLK = 1'b0;

      // cmd RAMWR, one pixel at the origin
      add(0, 8'h2C, 0, 0, 16'h0, 8'd0, 8'd0, 0);
      add(1, 8'hF8, 0, 0, 16'h0, 8'd0, 8'd0, 0);
      add(1, 8'h00, 0, 1, 16'hF800, 8'd0, 8'd0, 0);
      // CASET with start > end is rejected
      add(0, 8'h2A, 0, 0, 16'h0, 8'd0, 8'd0, 0);
      add(1, 8'h00, 0, 0, 16'h0, 8'd0, 8'd0, 0);
      add(1, 8'h0A, 0, 0, 16'h0, 8'd0, 8'd0, 0);
      add(1, 8'h00, 0, 0, 16'h0, 8'd0, 8'd0, 0);
      add(1, 8'h04, 1, 0, 16'h0, 8'd0, 8'd0, 0);
      add(0, 8'h2C, 0, 0, 16'h0, 8'd0, 8'd0, 0);
      add(1, 8'hAB, 0, 0, 16'h0, 8'd0, 8'd0, 0);
      add(1, 8'hCD, 0, 1, 16'hABCD, 8'd0, 8'd0, 0);
      // 2x2 window at (2..3, 5..6)
      add(0, 8'h2A, 0, 0, 16'h0, 8'd0, 8'd0, 0);
      add(1, 8'h00, 0, 0, 16'h0, 8'd0, 8'd0, 0);
      add(1, 8'h02, 0, 0, 16'h0, 8'd0, 8'd0, 0);
      add(1, 8'h00, 0, 0, 16'h0, 8'd0, 8'd0, 0);
      add(1, 8'h03, 0, 0, 16'h0, 8'd0, 8'd0, 0);
      add(0, 8'h2B, 0, 0, 16'h0, 8'd0, 8'd0, 0);
      add(1, 8'h00, 0, 0, 16'h0, 8'd0, 8'd0, 0);
      add(1, 8'h05, 0, 0, 16'h0, 8'd0, 8'd0, 0);
      add(1, 8'h00, 0, 0, 16'h0, 8'd0, 8'd0, 0);
      add(1, 8'h06, 0, 0, 16'h0, 8'd0, 8'd0, 0);
      add(0, 8'h2C, 0, 0, 16'h0, 8'd0, 8'd0, 0);
      add(1, 8'h11, 0, 0, 16'h0, 8'd0, 8'd0, 0);
      add(1, 8'h22, 0, 1, 16'h1122, 8'd2, 8'd5, 0);
      add(1, 8'h33, 0, 0, 16'h0, 8'd0, 8'd0, 0);
      add(1, 8'h44, 0, 1, 16'h3344, 8'd3, 8'd5, 0);
      add(1, 8'h55, 0, 0, 16'h0, 8'd0, 8'd0, 0);
      add(1, 8'h66, 0, 1, 16'h5566, 8'd2, 8'd6, 0);
      add(1, 8'h77, 0, 0, 16'h0, 8'd0, 8'd0, 0);
      add(1, 8'h88, 0, 1, 16'h7788, 8'd3, 8'd6, 1);
      add(1, 8'h99, 0, 0, 16'h0, 8'd0, 8'd0, 0);
      add(1, 8'hAA, 0, 1, 16'h99AA, 8'd2, 8'd5, 0);

      cyc(3);
      all_zero("reset_outputs");
      RST_N = 1'b1;
      cyc(4);
      CS = 1'b0;
      cyc(4);

      foreach (tbl[i]) begin
         b0 = byte_n; p0 = pix_n;
         e0 = err_n;  f0 = fd_n;
         send_bits(tbl[i].b, tbl[i].dc, 8);
         cyc(8);
         chk($sformatf("v%0d_bytes", i),
             64'(byte_n - b0), 64'd1);
         chk($sformatf("v%0d_data", i),
             64'(last_b), 64'(tbl[i].b));
         chk($sformatf("v%0d_dc", i),
             64'(last_dc), 64'(tbl[i].dc));
         chk($sformatf("v%0d_err", i),
             64'(err_n - e0), 64'(tbl[i].ex_err));
         chk($sformatf("v%0d_pix", i),
             64'(pix_n - p0), 64'(tbl[i].ex_pix));
         chk($sformatf("v%0d_fd", i),
             64'(fd_n - f0), 64'(tbl[i].ex_fd));
         if (tbl[i].ex_pix == 1) begin
            chk($sformatf("v%0d_pixel", i),
                64'(last_px), 64'(tbl[i].px));
            chk($sformatf("v%0d_x", i),
                64'(last_x), 64'(tbl[i].x));
            chk($sformatf("v%0d_y", i),
                64'(last_y), 64'(tbl[i].y));
         end
      end

      // Partial byte aborted by CS, then a clean byte
      b0 = byte_n; e0 = err_n;
      send_bits(8'hC3, 1'b1, 5);
      cyc(6);
      CS = 1'b1;
      cyc(10);
      chk("abort_err", 64'(err_n - e0), 64'd1);
      chk("abort_nobyte", 64'(byte_n - b0), 64'd0);
      CS = 1'b0;
      cyc(6);
      send_bits(8'h5A, 1'b1, 8);
      cyc(8);
      chk("after_abort_bytes",
          64'(byte_n - b0), 64'd1);
      chk("after_abort_data", 64'(last_b), 64'h5A);

      // High byte kept across a CS high gap
      p0 = pix_n; e0 = err_n;
      send_bits(8'h2C, 1'b0, 8);
      send_bits(8'h12, 1'b1, 8);
      cyc(6);
      CS = 1'b1;
      cyc(20);
      CS = 1'b0;
      cyc(6);
      send_bits(8'h34, 1'b1, 8);
      cyc(8);
      chk("cs_gap_pix", 64'(pix_n - p0), 64'd1);
      chk("cs_gap_pixel", 64'(last_px), 64'h1234);
      chk("cs_gap_x", 64'(last_x), 64'd2);
      chk("cs_gap_y", 64'(last_y), 64'd5);
      chk("cs_gap_err", 64'(err_n - e0), 64'd0);

      // A command between the two bytes drops the pixel
      p0 = pix_n;
      send_bits(8'h2C, 1'b0, 8);
      send_bits(8'h12, 1'b1, 8);
      send_bits(8'h00, 1'b0, 8);
      send_bits(8'h34, 1'b1, 8);
      cyc(8);
      chk("cmd_abort_pix", 64'(pix_n - p0), 64'd0);

      // Reset in the middle of RAMWR and of a byte
      send_bits(8'h2C, 1'b0, 8);
      send_bits(8'h55, 1'b1, 8);
      cyc(6);
      chk("pre_reset_data", 64'(BYTE_DATA), 64'h55);
      send_bits(8'hA5, 1'b1, 3);
      cyc(1);
      RST_N = 1'b0;
      CS    = 1'b1;
      #1;
      all_zero("mid_reset_outputs");
      cyc(4);
      RST_N = 1'b1;
      cyc(4);
      CS = 1'b0;
      cyc(6);
      p0 = pix_n;
      send_bits(8'h2C, 1'b0, 8);
      send_bits(8'hDE, 1'b1, 8);
      send_bits(8'hAD, 1'b1, 8);
      cyc(8);
      chk("post_reset_pix", 64'(pix_n - p0), 64'd1);
      chk("post_reset_pixel", 64'(last_px), 64'hDEAD);
      chk("post_reset_x", 64'(last_x), 64'd0);
      chk("post_reset_y", 64'(last_y), 64'd0);
      send_bits(8'hBE, 1'b1, 8);
      send_bits(8'hEF, 1'b1, 8);
      cyc(8);
      chk("post_reset_x2", 64'(last_x), 64'd1);
      chk("post_reset_y2", 64'(last_y), 64'd0);

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule

// File: doc/st7735_spi_rx.md
Name: st7735_spi_rx

Overview:
Display-side receiver for the 4-wire ST7735 SPI link (CS, MOSI, DC, LCD_CLK) that the LCD driver produces. It oversamples the link on SYSTEM_CLK and recovers command and data bytes. It tracks CASET, RASET and RAMWR, and emits 16-bit pixels tagged with their window coordinates. Used for on-FPGA loopback checking of the driver and as a display model in benches.

Parameters:
SYNC_STAGES, 2, synchronizer depth on CS/MOSI/DC/LCD_CLK (min 2)
WIDTH, 128, panel columns; column addresses must be < WIDTH
HEIGHT, 160, panel rows; row addresses must be < HEIGHT

Ports:
SYSTEM_CLK  in  1  sole clock; must be >= 4x LCD_CLK frequency
RST_N  in  1  asynchronous active-low reset
CS  in  1  chip select, active low
MOSI  in  1  serial data, MSB first, sampled on LCD_CLK rising
DC  in  1  0 = command byte, 1 = data byte; sampled with the byte's last bit
LCD_CLK  in  1  SPI clock, idle low
BYTE_VALID  out  1  one-cycle pulse, byte received
BYTE_DATA  out  8  received byte
BYTE_IS_DATA  out  1  DC value latched for BYTE_DATA
PIXEL_VALID  out  1  one-cycle pulse, pixel assembled
PIXEL  out  16  RGB565 pixel, first byte = [15:8]
PIXEL_X  out  8  column of PIXEL
PIXEL_Y  out  8  row of PIXEL
FRAME_DONE  out  1  one-cycle pulse coincident with PIXEL_VALID of the window's last pixel
ERR  out  1  one-cycle pulse on a protocol error

Behaviour:
- Reset: all outputs 0. Synchronized CS resets to 1; other synchronized inputs reset to 0. Window resets to xs=0, xe=WIDTH-1, ys=0, ye=HEIGHT-1. FSM resets to IDLE.
- Bit level: a rising edge of synchronized LCD_CLK while synchronized CS=0 shifts MOSI into an 8-bit register. A 3-bit counter tracks position in the byte.
  - On the 8th edge, DC is latched. BYTE_DATA and BYTE_IS_DATA are updated and BYTE_VALID pulses on the following SYSTEM_CLK cycle.
  - Latency from LCD_CLK pin edge to BYTE_VALID: SYNC_STAGES+2 cycles.
- CS falling edge clears the bit counter.
- CS rising with the counter != 0: partial byte discarded, counter cleared, ERR pulses.
- CS toggling never alters byte-level state. A pending RAMWR high byte is kept across CS high.
- Byte FSM, driven only by BYTE_VALID:
  - IDLE: a command byte selects the next state. 0x2A -> CASET, 0x2B -> RASET, 0x2C -> RAMWR_HI (x=xs, y=ys). Any other command -> IDLE. Data bytes in IDLE are ignored.
  - CASET / RASET: collect 4 data bytes (start hi, start lo, end hi, end lo) into shadow registers, then go to IDLE.
    - After the 4th byte the new window is committed only if start <= end and end < WIDTH (or HEIGHT for RASET), with both hi bytes 0.
    - Otherwise the window is unchanged and ERR pulses in the same cycle the 4th byte is consumed.
  - RAMWR_HI: a data byte is stored as the pixel high byte -> RAMWR_LO.
  - RAMWR_LO: a data byte completes the pixel.
    - Next cycle: PIXEL_VALID pulses with the current x, y, then the pointer advances.
    - Advance rule: if x==xe then x=xs and (if y==ye then y=ys and FRAME_DONE pulses, else y+1), else x+1.
    - Then -> RAMWR_HI. RAMWR continues indefinitely, wrapping over the window.
  - Any command byte in any state aborts the current sequence (partial CASET/RASET discarded, pending high byte discarded) and is decoded as from IDLE.
- Window changes take effect at the next RAMWR; an in-progress RAMWR pointer is unaffected.

Decomposition:
- Shared package st7735_pkg: command opcodes CMD_CASET=8'h2A, CMD_RASET=8'h2B, CMD_RAMWR=8'h2C; the FSM state enum (IDLE, CASET, RASET, RAMWR_HI, RAMWR_LO); default WIDTH/HEIGHT constants, shared with the transmit driver.
- One sub-module, spi_byte_rx: synchronizers, edge detect, shift register, bit counter, CS-abort ERR. It outputs byte/dc/valid.
- st7735_spi_rx holds the command FSM, window registers and pixel pointer.

Test Plan:
1. Reset, CS low, send cmd 0x2C, then data 0xF8,0x00 at SYSTEM_CLK/8 -> BYTE_VALID x3, PIXEL_VALID once with PIXEL=16'hF800, X=0, Y=0.
2. CASET 0,2,0,3; RASET 0,5,0,6; RAMWR; 5 pixels -> coordinates (2,5),(3,5),(2,6),(3,6),(2,5); FRAME_DONE only with (3,6).
3. CASET 0,10,0,4 (start>end), then RAMWR + 1 pixel -> ERR one pulse, pixel at (0,0) with the reset window intact.
4. Deassert CS after 5 bits of a data byte -> ERR pulse, no BYTE_VALID; next full byte is received correctly.
5. RAMWR, high byte 0x12, CS high 20 cycles, CS low, low byte 0x34 -> PIXEL=16'h1234. Repeat with cmd 0x00 between bytes -> no PIXEL_VALID.
6. Assert RST_N low mid-byte and mid-RAMWR -> all outputs 0 immediately, window restored, next RAMWR starts at (0,0).
